// File: rtl/fu_resp_queue.sv
// In-order result queue between a function unit and the execute-unit arbiter:
// up to wwd results enter per cycle, the oldest ewd are presented as claimable lanes.
module fu_resp_queue #(
    parameter int unsigned ewd   = 2,
    parameter int unsigned wwd   = 2,
    parameter int unsigned depth = 8,
    parameter int unsigned dwd   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [wwd-1:0][dwd-1:0]       in_data,
    output logic                          in_ready,
    output logic [ewd-1:0][dwd-1:0]       fu_resp,
    input  logic [ewd-1:0]                fu_claim,
    output logic [$clog2(depth):0]        count,
    output logic                          ovf_err
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned CW = AW + 1;

    logic [dwd-1:0]          r_mem [depth];
    logic [AW-1:0]           r_head;
    logic [AW-1:0]           r_tail;
    logic [CW-1:0]           r_count;
    logic                    r_ovf_err;

    logic [CW-1:0]           w_deq;
    logic                    w_run;
    logic [ewd-1:0]          w_claim_ok;
    logic                    w_claim_err;
    logic [CW-1:0]           w_enq;
    logic [wwd-1:0]          w_valid;
    logic [wwd-1:0]          w_wr_en;
    logic [wwd-1:0][AW-1:0]  w_wr_ptr;
    logic                    w_drop;

    assign in_ready = ((CW'(depth) - r_count) >= CW'(wwd));
    assign count    = r_count;
    assign ovf_err  = r_ovf_err;

    always_comb begin
        for (int unsigned j = 0; j < ewd; j++) begin
            fu_resp[j] = '0;
            if (CW'(j) < r_count) fu_resp[j] = r_mem[r_head + AW'(j)];
        end
    end

    // Dequeue only the unbroken run of claims starting at lane 0; anything else is an error.
    always_comb begin
        w_deq      = '0;
        w_run      = 1'b1;
        w_claim_ok = '0;
        for (int unsigned j = 0; j < ewd; j++) begin
            if (w_run && fu_claim[j] && (CW'(j) < r_count)) begin
                w_deq         = w_deq + CW'(1);
                w_claim_ok[j] = 1'b1;
            end else begin
                w_run = 1'b0;
            end
        end
        w_claim_err = |(fu_claim & ~w_claim_ok);
    end

    // Valid ports are packed into consecutive slots starting at tail.
    always_comb begin
        w_enq    = '0;
        w_wr_en  = '0;
        w_wr_ptr = '0;
        for (int unsigned k = 0; k < wwd; k++) begin
            w_valid[k]  = in_data[k][15];
            w_wr_ptr[k] = r_tail + w_enq[AW-1:0];
            if (in_ready && w_valid[k]) begin
                w_wr_en[k] = 1'b1;
                w_enq      = w_enq + CW'(1);
            end
        end
        w_drop = !in_ready && (|w_valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_ovf_err <= 1'b0;
            for (int unsigned i = 0; i < depth; i++) r_mem[i] <= '0;
        end else begin
            r_ovf_err <= r_ovf_err | w_drop | w_claim_err;
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + w_deq[AW-1:0];
                r_tail  <= r_tail + w_enq[AW-1:0];
                r_count <= r_count + w_enq - w_deq;
                for (int unsigned k = 0; k < wwd; k++) begin
                    if (w_wr_en[k]) r_mem[w_wr_ptr[k]] <= in_data[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_fu_resp_queue.sv
// Randomized and directed checking of fu_resp_queue against a queue-based model.
module tb_fu_resp_queue;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [1:0][63:0] in_data;
    logic             in_ready;
    logic [1:0][63:0] fu_resp;
    logic [1:0]       fu_claim;
    logic [3:0]       count;
    logic             ovf_err;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [63:0] m_q [$];
    logic        m_err;
    int unsigned seq;

    fu_resp_queue #(.ewd(2), .wwd(2), .depth(8), .dwd(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data),
        .in_ready(in_ready), .fu_resp(fu_resp), .fu_claim(fu_claim),
        .count(count), .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int j = 0; j < 2; j++)
            check($sformatf("lane%0d", j), fu_resp[j], (j < m_q.size()) ? m_q[j] : 64'd0);
        check("count", 64'(count), 64'(m_q.size()));
        check("in_ready", 64'(in_ready), 64'((8 - m_q.size()) >= 2));
        check("ovf_err", 64'(ovf_err), 64'(m_err));
    endtask

    function automatic logic [63:0] mk(input logic v, input logic [14:0] id);
        logic [63:0] x;
        x = {$urandom, $urandom};
        x[15] = v;
        x[14:0] = id;
        return x;
    endfunction

    // Called at the negedge: check, drive, and advance the model to the post-edge state.
    task automatic step(input logic fl, input logic [63:0] d0, input logic [63:0] d1,
                        input logic [1:0] cl);
        int  d;
        bit  rdy;
        check_outputs();
        flush = fl; in_data[0] = d0; in_data[1] = d1; fu_claim = cl;
        d = 0;
        for (int j = 0; j < 2; j++)
            if (cl[j] && d == j && j < m_q.size()) d++;
        for (int j = 0; j < 2; j++)
            if (cl[j] && j >= d) m_err = 1'b1;
        rdy = (8 - m_q.size()) >= 2;
        if (!rdy && (d0[15] || d1[15])) m_err = 1'b1;
        if (fl) m_q.delete();
        else begin
            repeat (d) void'(m_q.pop_front());
            if (rdy && d0[15]) m_q.push_back(d0);
            if (rdy && d1[15]) m_q.push_back(d1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        flush = 1'b0; in_data = '0; fu_claim = '0;
        #1;
        m_q.delete();
        m_err = 1'b0;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; m_err = 1'b0; seq = 0;
        rst = 1'b0; flush = 1'b0; in_data = '0; fu_claim = '0;
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;
        @(negedge clk);

        // basic enqueue / partial claim
        step(0, mk(1, 15'h0001), mk(1, 15'h0002), 2'b00);
        step(0, '0, '0, 2'b01);
        step(0, '0, '0, 2'b00);
        step(0, '0, '0, 2'b01);

        // fill, overflow drop, then drain two
        for (int i = 0; i < 4; i++)
            step(0, mk(1, 15'(16'h10 + 2*i)), mk(1, 15'(16'h11 + 2*i)), 2'b00);
        step(0, mk(1, 15'h0018), mk(0, 15'h0), 2'b00);
        step(0, '0, '0, 2'b11);
        step(0, '0, '0, 2'b00);

        // single-entry fill to reach count 7
        do_reset();
        for (int i = 0; i < 7; i++) step(0, mk(1, 15'(16'h30 + i)), mk(0, 15'h0), 2'b00);
        step(0, '0, '0, 2'b00);

        // wrap-around at constant occupancy
        do_reset();
        step(0, mk(1, 15'h0100), mk(1, 15'h0101), 2'b00);
        for (int i = 0; i < 8; i++)
            step(0, mk(1, 15'(16'h102 + 2*i)), mk(1, 15'(16'h103 + 2*i)), 2'b11);
        step(0, '0, '0, 2'b11);

        // sparse enqueue
        step(0, mk(0, 15'h7fff), mk(1, 15'h0020), 2'b00);
        step(0, mk(1, 15'h0021), mk(0, 15'h0), 2'b00);

        // flush overrides claim and enqueue
        do_reset();
        step(0, mk(1, 15'h40), mk(1, 15'h41), 2'b00);
        step(0, mk(1, 15'h42), mk(1, 15'h43), 2'b00);
        step(0, mk(1, 15'h44), mk(0, 15'h0), 2'b00);
        step(1, mk(1, 15'h45), mk(1, 15'h46), 2'b11);
        step(0, '0, '0, 2'b00);

        // illegal claim pattern, then reset mid-cycle
        step(0, mk(1, 15'h50), mk(1, 15'h51), 2'b00);
        step(0, '0, '0, 2'b10);
        step(0, '0, '0, 2'b00);
        do_reset();

        // randomized traffic
        seq = 16'h200;
        for (int i = 0; i < 3000; i++) begin
            logic v0, v1, fl;
            logic [1:0] cl;
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: cl = 2'b00;
                3, 4:    cl = 2'b01;
                5, 6, 7: cl = 2'b11;
                8:       cl = 2'b10;
                default: cl = 2'($urandom);
            endcase
            if (m_q.size() == 0 && cl != 2'b00 && $urandom_range(0, 1) == 0) cl = 2'b00;
            if (m_q.size() == 1 && cl == 2'b11 && $urandom_range(0, 1) == 0) cl = 2'b01;
            step(fl, mk(v0, 15'(seq)), mk(v1, 15'(seq + 1)), cl);
            seq += 2;
            if ($urandom_range(0, 149) == 0) do_reset();
        end
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
